// File: rtl/store_queue.sv
// In-order store buffer between the MEM-stage store aligner and the dmem write port.
// Optional macro SQ_COALESCE_EN merges a store into the tail entry when it hits the same word.
module store_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            st_valid,
    output logic            st_ready,
    input  logic [XLEN-1:0] st_addr,
    input  logic [XLEN-1:0] st_wdata,
    input  logic [3:0]      st_be,
    input  logic            ld_chk_valid,
    input  logic [XLEN-1:0] ld_chk_addr,
    output logic            ld_conflict,
    output logic            dm_req,
    output logic [XLEN-1:0] dm_addr,
    output logic [XLEN-1:0] dm_wdata,
    output logic [3:0]      dm_be,
    input  logic            dm_ack,
    output logic            sq_empty,
    output logic            sq_full
);
    localparam int AW = $clog2(DEPTH);
    localparam int WW = XLEN - 2;

    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
    logic [AW-1:0] wr_idx, rd_idx;
    logic          push, pop, merge, full, empty;

    logic [DEPTH-1:0][WW-1:0]   addr_q, addr_d;
    logic [DEPTH-1:0][XLEN-1:0] data_q, data_d;
    logic [DEPTH-1:0][3:0]      be_q, be_d;
    logic [DEPTH-1:0]           entry_valid, entry_hit;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{st_addr[1:0], ld_chk_addr[1:0]};

    assign wr_idx = wr_ptr_q[AW-1:0];
    assign rd_idx = rd_ptr_q[AW-1:0];
    assign count  = wr_ptr_q - rd_ptr_q;
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_idx == rd_idx) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

`ifdef SQ_COALESCE_EN
    logic [AW-1:0] tail_idx;
    logic          tail_hit;
    assign tail_idx = wr_idx - AW'(1);
    // count>=2 keeps the head (possibly already on the dmem bus) out of reach of a merge.
    assign tail_hit = (count >= (AW+1)'(2)) && (addr_q[tail_idx] == st_addr[XLEN-1:2]);
    assign merge    = st_valid && tail_hit;
    assign st_ready = !full || tail_hit;
`else
    assign merge    = 1'b0;
    assign st_ready = !full;
`endif

    assign push   = st_valid && st_ready && !merge;
    assign dm_req = !empty;
    assign pop    = dm_req && dm_ack;

    assign wr_ptr_d = wr_ptr_q + (AW+1)'(push);
    assign rd_ptr_d = rd_ptr_q + (AW+1)'(pop);

    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        be_d   = be_q;
        if (push) begin
            addr_d[wr_idx] = st_addr[XLEN-1:2];
            data_d[wr_idx] = st_wdata;
            be_d[wr_idx]   = st_be;
        end
`ifdef SQ_COALESCE_EN
        if (merge) begin
            for (int b = 0; b < 4; b++) begin
                if (st_be[b]) begin
                    data_d[tail_idx][8*b +: 8] = st_wdata[8*b +: 8];
                end
            end
            be_d[tail_idx] = be_q[tail_idx] | st_be;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Payload needs no reset: the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
        be_q   <= be_d;
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [AW-1:0] offset;
        assign offset          = AW'(gi) - rd_idx;
        assign entry_valid[gi] = ({1'b0, offset} < count);
        assign entry_hit[gi]   = entry_valid[gi] && (addr_q[gi] == ld_chk_addr[XLEN-1:2]);
    end

    assign ld_conflict = ld_chk_valid && (|entry_hit);
    assign dm_addr     = {addr_q[rd_idx], 2'b00};
    assign dm_wdata    = data_q[rd_idx];
    assign dm_be       = be_q[rd_idx];
    assign sq_empty    = empty;
    assign sq_full     = full;
endmodule

// File: tb/tb_store_queue.sv
// Directed bench for store_queue; define SQ_COALESCE_EN to exercise the merging build.
module tb_store_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid, st_ready;
    logic [31:0] st_addr, st_wdata;
    logic [3:0]  st_be;
    logic        ld_chk_valid, ld_conflict;
    logic [31:0] ld_chk_addr;
    logic        dm_req, dm_ack;
    logic [31:0] dm_addr, dm_wdata;
    logic [3:0]  dm_be;
    logic        sq_empty, sq_full;

    int errors = 0;
    int checks = 0;

    store_queue #(.DEPTH(4), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
        .st_wdata(st_wdata), .st_be(st_be),
        .ld_chk_valid(ld_chk_valid), .ld_chk_addr(ld_chk_addr), .ld_conflict(ld_conflict),
        .dm_req(dm_req), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
        .dm_ack(dm_ack), .sq_empty(sq_empty), .sq_full(sq_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        st_valid = 1'b1; st_addr = a; st_wdata = d; st_be = b;
        tick();
        st_valid = 1'b0;
    endtask

    task automatic drain_check(input string tag, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] b);
        dm_ack = 1'b1;
        #1;
        check({tag, "_req"}, 32'(dm_req), 32'd1);
        check({tag, "_addr"}, dm_addr, a);
        check({tag, "_data"}, dm_wdata, d);
        check({tag, "_be"}, 32'(dm_be), 32'(b));
        tick();
        dm_ack = 1'b0;
    endtask

    logic [31:0] qa[$];
    logic [31:0] qd[$];
    logic [3:0]  qb[$];
    int          seen;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_wdata = '0; st_be = '0;
        ld_chk_valid = 1'b0; ld_chk_addr = '0; dm_ack = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_empty", 32'(sq_empty), 32'd1);
        check("rst_full", 32'(sq_full), 32'd0);
        check("rst_req", 32'(dm_req), 32'd0);
        check("rst_ready", 32'(st_ready), 32'd1);
        check("rst_conflict", 32'(ld_conflict), 32'd0);

        // Single word store held for three un-acked cycles
        put(32'h1000, 32'hDEADBEEF, 4'hF);
        for (int c = 0; c < 3; c++) begin
            check("sw_hold_req", 32'(dm_req), 32'd1);
            check("sw_hold_addr", dm_addr, 32'h1000);
            check("sw_hold_data", dm_wdata, 32'hDEADBEEF);
            tick();
        end
        drain_check("sw_ack", 32'h1000, 32'hDEADBEEF, 4'hF);
        check("sw_empty", 32'(sq_empty), 32'd1);
        check("sw_req_low", 32'(dm_req), 32'd0);

        // Fill, refuse the fifth store even across a same-cycle ack
        for (int i = 0; i < 4; i++) put(32'h10 + 32'(4*i), 32'hA0A00000 + 32'(i), 4'(i+1));
        st_valid = 1'b1; st_addr = 32'h20; st_wdata = 32'hA0A00004; st_be = 4'hF;
        #1;
        check("full_flag", 32'(sq_full), 32'd1);
        check("full_refuse", 32'(st_ready), 32'd0);
        tick();
        check("full_head_kept", dm_addr, 32'h10);
        dm_ack = 1'b1;
        #1;
        check("full_ack_refuse", 32'(st_ready), 32'd0);
        tick();
        dm_ack = 1'b0;
        #1;
        check("full_after_ack", 32'(sq_full), 32'd0);
        check("full_ready_again", 32'(st_ready), 32'd1);
        check("full_new_head", dm_addr, 32'h14);
        tick();
        st_valid = 1'b0;
        check("full_refilled", 32'(sq_full), 32'd1);
        for (int i = 1; i < 5; i++)
            drain_check("full_drain", 32'h10 + 32'(4*i), 32'hA0A00000 + 32'(i),
                        (i == 4) ? 4'hF : 4'(i+1));
        check("full_drained", 32'(sq_empty), 32'd1);

        // Streaming through the pointer wrap with dm_ack held high
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            st_valid = (c < 10);
            st_addr  = 32'h100 + 32'(4*c + c%4);
            st_wdata = 32'h5A000000 | 32'(c);
            st_be    = 4'(c);
            dm_ack   = 1'b1;
            #1;
            check("wrap_ready", 32'(st_ready), 32'd1);
            check("wrap_req", 32'(dm_req), 32'(qa.size() != 0));
            if (qa.size() != 0) begin
                check("wrap_addr", dm_addr, qa.pop_front());
                check("wrap_data", dm_wdata, qd.pop_front());
                check("wrap_be", 32'(dm_be), 32'(qb.pop_front()));
                seen++;
            end
            if (st_valid) begin
                qa.push_back(st_addr & 32'hFFFFFFFC);
                qd.push_back(st_wdata);
                qb.push_back(st_be);
            end
            tick();
        end
        st_valid = 1'b0; dm_ack = 1'b0;
        check("wrap_count", 32'(seen), 32'd10);
        check("wrap_empty", 32'(sq_empty), 32'd1);

        // Load-hit detection against pending words
        put(32'h2004, 32'h12345678, 4'hF);
        ld_chk_valid = 1'b1; ld_chk_addr = 32'h2006;
        #1 check("ld_hit", 32'(ld_conflict), 32'd1);
        ld_chk_addr = 32'h2008;
        #1 check("ld_miss", 32'(ld_conflict), 32'd0);
        ld_chk_valid = 1'b0; ld_chk_addr = 32'h2006;
        #1 check("ld_novalid", 32'(ld_conflict), 32'd0);
        ld_chk_valid = 1'b1; dm_ack = 1'b1;
        #1 check("ld_head_until_ack", 32'(ld_conflict), 32'd1);
        tick();
        dm_ack = 1'b0;
        #1 check("ld_after_ack", 32'(ld_conflict), 32'd0);
        ld_chk_valid = 1'b0;

        // Tail-word store: merged or allocated depending on build
        put(32'h30, 32'h11111111, 4'hF);
        put(32'h40, 32'h22222222, 4'h1);
        put(32'h41, 32'h0000AA00, 4'h2);
        put(32'h30, 32'h0000AA00, 4'h2);
        ld_chk_valid = 1'b1; ld_chk_addr = 32'h40;
        #1 check("ld_tail_hit", 32'(ld_conflict), 32'd1);
        ld_chk_valid = 1'b0;
        drain_check("co_head", 32'h30, 32'h11111111, 4'hF);
`ifdef SQ_COALESCE_EN
        drain_check("co_merged", 32'h40, 32'h2222AA22, 4'h3);
`else
        drain_check("co_first", 32'h40, 32'h22222222, 4'h1);
        drain_check("co_second", 32'h40, 32'h0000AA00, 4'h2);
`endif
        drain_check("co_new", 32'h30, 32'h0000AA00, 4'h2);
        check("co_empty", 32'(sq_empty), 32'd1);

        // Reset while entries are outstanding
        put(32'h50, 32'h50, 4'hF);
        put(32'h54, 32'h54, 4'hF);
        put(32'h58, 32'h58, 4'hF);
        check("mr_req_before", 32'(dm_req), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_req_low", 32'(dm_req), 32'd0);
        check("mr_empty", 32'(sq_empty), 32'd1);
        dm_ack = 1'b1;
        tick();
        dm_ack = 1'b0;
        #1;
        check("mr_ack_ignored", 32'(sq_empty), 32'd1);
        check("mr_ready", 32'(st_ready), 32'd1);
        put(32'h60, 32'h66666666, 4'h5);
        drain_check("mr_fresh", 32'h60, 32'h66666666, 4'h5);
        check("mr_final_empty", 32'(sq_empty), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
